program_arbiter: RTL
====================

PROGRAM_ARBITER -- requirements
Module: program_arbiter

Interface
REQ-001 SHALL provide parameter DATA_W, default 801, payload width of every data lane.
REQ-002 SHALL provide parameter FIFO_DEPTH, default 8, uplink FIFO depth; power of two, at least 2.
REQ-003 SHALL provide parameter ACK_TIMEOUT, default 1024, maximum downlink delivery cycles.
REQ-004 SHALL provide port clk, input, 1, rising-edge clock; one clock domain.
REQ-005 SHALL provide port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL provide port prog_req, input, 4, per-programmer uplink request.
REQ-007 SHALL provide port prog_data, input, 4*DATA_W, lane i at [i*DATA_W +: DATA_W].
REQ-008 SHALL provide port prog_grant, output, 4, one-hot accept pulse.
REQ-009 SHALL provide port tx_data, output, DATA_W, word to the USB tx FIFO.
REQ-010 SHALL provide port tx_enable, output, 1, tx write strobe.
REQ-011 SHALL provide port tx_full, input, 1, tx FIFO cannot accept.
REQ-012 SHALL provide port rx_data, input, DATA_W, USB rx word, valid the cycle after rx_enable.
REQ-013 SHALL provide port rx_enable, output, 1, rx pop strobe.
REQ-014 SHALL provide port rx_empty, input, 1, rx FIFO empty.
REQ-015 SHALL provide port prog_rx_data, output, DATA_W, broadcast downlink word.
REQ-016 SHALL provide port prog_rx_valid, output, 4, per-programmer downlink valid.
REQ-017 SHALL provide port prog_rx_ack, input, 4, per-programmer downlink accept.
REQ-018 SHALL provide port fifo_level, output, clog2(FIFO_DEPTH)+1, uplink occupancy.
REQ-019 SHALL provide port rx_timeout, output, 1, one-cycle pulse on delivery timeout.

Function
REQ-020 SHALL grant at most one requester per edge, only when pre-edge fifo_level < FIFO_DEPTH.
REQ-021 SHALL arbitrate round-robin, searching from last_grant+1 mod 4; last_grant updates on every grant.
REQ-022 SHALL assert prog_grant[i] for exactly the cycle in which lane i is written into the FIFO (combinational grant, write at that edge).
REQ-023 SHALL require requesters to hold prog_req and data until granted; a dropped request is not captured.
REQ-024 SHALL implement a strict FIFO: wr_ptr/rd_ptr wrap modulo FIFO_DEPTH; words are emitted in grant order.
REQ-025 SHALL, at each edge where pre-edge level > 0 and tx_full = 0, register head into tx_data, set tx_enable = 1, and advance rd_ptr; otherwise set tx_enable = 0 and hold tx_data.
REQ-026 SHALL, on simultaneous push and pop, leave fifo_level unchanged; a full FIFO with a pop still withholds the grant that edge.
REQ-027 SHALL run downlink FSM RX_IDLE -> RX_WAIT -> RX_DELIVER -> RX_IDLE.
REQ-028 SHALL in RX_IDLE with rx_empty = 0, drive rx_enable = 1 for one cycle and enter RX_WAIT.
REQ-029 SHALL in RX_WAIT, capture rx_data into prog_rx_data, set prog_rx_valid = 4'b1111, clear the timeout counter, and enter RX_DELIVER.
REQ-030 SHALL in RX_DELIVER, clear prog_rx_valid[i] at the edge where prog_rx_ack[i] = 1, and return to RX_IDLE once all bits are clear; prog_rx_data holds throughout.
REQ-031 SHALL, when RX_DELIVER lasts ACK_TIMEOUT cycles, clear all valid bits, pulse rx_timeout, and return to RX_IDLE.
REQ-032 SHALL run the uplink and downlink paths independently and concurrently.

Reset
REQ-033 SHALL, on reset_n low: all outputs 0, pointers and level 0, last_grant 3 (lane 0 first), FSM RX_IDLE, timeout counter 0.
REQ-034 SHALL discard FIFO contents and any in-flight downlink word on reset mid-operation; no strobe is issued in the release cycle.

Structure
REQ-035 SHALL place N_REQ=4, DATA_W default, and the downlink state enum in shared package program_arbiter_pkg.
REQ-036 SHALL implement arbitration in sub-module rr_arbiter4 (req, last_grant -> one-hot grant); FIFO and FSM stay inline.

Verification
REQ-037 SHALL test: prog_req=4'b1111 held, tx_full=0 -> grants 0,1,2,3,0 on consecutive cycles; tx_data follows the same order.
REQ-038 SHALL test: tx_full=1 and 9 requests -> 8 grants, fifo_level=8, no further grant; release tx_full -> 8 words out FIFO-order.
REQ-039 SHALL test: level=8 with tx_full=0 and req active -> no grant that edge; grant the next edge; level stays at most 8.
REQ-040 SHALL test: rx_empty=0, rx_data=0x5A -> rx_enable pulse, prog_rx_data=0x5A, valid=1111; acks on lanes 2,0,3,1 on separate cycles -> valid clears per lane, FSM returns to RX_IDLE.
REQ-041 SHALL test: lane 3 never acks -> rx_timeout pulse after exactly 1024 RX_DELIVER cycles, valid=0000.
REQ-042 SHALL test: reset_n low with 5 words queued and RX_DELIVER active -> outputs 0 immediately, level 0, no tx_enable after release.

Source files
------------

// File: rtl/program_arbiter_pkg.sv
// Shared constants and downlink state type for the programmer arbiter.
package program_arbiter_pkg;

  localparam int N_REQ      = 4;
  localparam int DATA_W_DEF = 801;

  typedef enum logic [1:0] {
    RX_IDLE    = 2'd0,
    RX_WAIT    = 2'd1,
    RX_DELIVER = 2'd2
  } rx_state_e;

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter: search starts one past the last granted lane.
module rr_arbiter4
  import program_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       last_grant,
  output logic [N_REQ-1:0] grant
);

  logic [1:0] idx;
  logic       found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = last_grant + 2'(k);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/program_arbiter.sv
// Uplink: four programmers -> round-robin -> FIFO -> USB tx.
// Downlink: USB rx word broadcast to all programmers until each acks or time runs out.
//
// state      | meaning
// RX_IDLE    | waiting for rx FIFO to hold a word; pops it when it does
// RX_WAIT    | popped word appears on rx_data; capture and raise all valids
// RX_DELIVER | waiting for every programmer to ack, bounded by ACK_TIMEOUT
module program_arbiter
  import program_arbiter_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int FIFO_DEPTH  = 8,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [N_REQ-1:0]            prog_req,
  input  logic [N_REQ*DATA_W-1:0]     prog_data,
  output logic [N_REQ-1:0]            prog_grant,
  output logic [DATA_W-1:0]           tx_data,
  output logic                        tx_enable,
  input  logic                        tx_full,
  input  logic [DATA_W-1:0]           rx_data,
  output logic                        rx_enable,
  input  logic                        rx_empty,
  output logic [DATA_W-1:0]           prog_rx_data,
  output logic [N_REQ-1:0]            prog_rx_valid,
  input  logic [N_REQ-1:0]            prog_rx_ack,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        rx_timeout
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int TMO_W = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [1:0]        last_grant;
  logic [1:0]        grant_idx;
  logic [N_REQ-1:0]  arb_grant;
  logic              push;
  logic              pop;

  rr_arbiter4 u_arb (
    .req        (prog_req),
    .last_grant (last_grant),
    .grant      (arb_grant)
  );

  // Grant is combinational so the requester sees it in the cycle its word is written.
  assign prog_grant = (reset_n && (fifo_level < LVL_FULL)) ? arb_grant : '0;
  assign push       = |prog_grant;
  assign pop        = (fifo_level != '0) && !tx_full;

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < N_REQ; i++)
      if (prog_grant[i]) grant_idx = 2'(i);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= prog_data[grant_idx*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      last_grant <= 2'd3;
      tx_data    <= '0;
      tx_enable  <= 1'b0;
    end else begin
      tx_enable <= pop;
      if (push) begin
        wr_ptr     <= wr_ptr + 1'b1;
        last_grant <= grant_idx;
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        tx_data <= mem[rd_ptr];
      end
      if (push && !pop)
        fifo_level <= fifo_level + 1'b1;
      else if (pop && !push)
        fifo_level <= fifo_level - 1'b1;
    end
  end

  rx_state_e        rx_state;
  logic [TMO_W-1:0] tmo_cnt;
  logic [N_REQ-1:0] valid_nxt;

  // rx_data arrives one cycle after the pop, so the pop strobe comes straight from IDLE.
  assign rx_enable = reset_n && (rx_state == RX_IDLE) && !rx_empty;
  assign valid_nxt = prog_rx_valid & ~prog_rx_ack;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state      <= RX_IDLE;
      tmo_cnt       <= '0;
      prog_rx_data  <= '0;
      prog_rx_valid <= '0;
      rx_timeout    <= 1'b0;
    end else begin
      rx_timeout <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (!rx_empty) rx_state <= RX_WAIT;
        end
        RX_WAIT: begin
          prog_rx_data  <= rx_data;
          prog_rx_valid <= '1;
          tmo_cnt       <= '0;
          rx_state      <= RX_DELIVER;
        end
        RX_DELIVER: begin
          if (valid_nxt == '0) begin
            prog_rx_valid <= '0;
            rx_state      <= RX_IDLE;
          end else if (tmo_cnt == TMO_LAST) begin
            prog_rx_valid <= '0;
            rx_timeout    <= 1'b1;
            rx_state      <= RX_IDLE;
          end else begin
            prog_rx_valid <= valid_nxt;
            tmo_cnt       <= tmo_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule
